// File: rtl/gf163_digit_serializer_if.sv
// Operand-in / digit-out bundle for the GF(2^163) digit serializer.
// The master modport is the serializer; the slave modport is its operand source and digit consumer.
interface gf163_digit_serializer_if #(
  parameter int NBITS = 163,
  parameter int DW    = 16
);
  logic             in_valid;
  logic             in_ready;
  logic [NBITS-1:0] in_data;
  logic             dig_valid;
  logic             dig_ready;
  logic [DW-1:0]    dig_out;
  logic             dig_first;
  logic             dig_last;
  logic             busy;

  modport master (
    input  in_valid, in_data, dig_ready,
    output in_ready, dig_valid, dig_out, dig_first, dig_last, busy
  );

  modport slave (
    output in_valid, in_data, dig_ready,
    input  in_ready, dig_valid, dig_out, dig_first, dig_last, busy
  );
endinterface

// File: rtl/gf163_digit_serializer.sv
// Splits one 163-bit GF(2^163) operand into eleven 16-bit digits for a D=16 multiplier.
// Digits go out MSB-first by default; define GF163_SER_LSB_FIRST_EN for LSB-first order.
module gf163_digit_serializer #(
  parameter  int NBITS = 163,
  parameter  int DW    = 16,
  localparam int ND    = (NBITS + DW - 1) / DW,
  localparam int BW    = ND * DW,
  localparam int CW    = $clog2(ND)
) (
  input logic clk,
  input logic rstn,
  gf163_digit_serializer_if.master bus
);

  typedef enum logic {IDLE = 1'b0, SHIFT = 1'b1} state_e;

  state_e        state_q, state_d;
  logic [BW-1:0] buf_q, buf_d;
  logic [CW-1:0] cnt_q, cnt_d;

  logic is_shift;
  logic is_last;
  logic load;
  logic advance;

  assign is_shift = (state_q == SHIFT);
  assign is_last  = is_shift && (cnt_q == CW'(ND - 1));

  // A last-digit transfer frees the buffer in the same edge, so a new operand may load then.
  assign bus.in_ready = !is_shift || (is_last && bus.dig_ready);
  assign load         = bus.in_valid && bus.in_ready;
  assign advance      = is_shift && bus.dig_ready && !is_last;

  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    state_d = state_q;
    buf_d   = buf_q;
    cnt_d   = cnt_q;
    if (load) begin
      state_d = SHIFT;
      buf_d   = BW'(bus.in_data);
      cnt_d   = '0;
    end else if (advance) begin
`ifdef GF163_SER_LSB_FIRST_EN
      buf_d = {{DW{1'b0}}, buf_q[BW-1:DW]};
`else
      buf_d = {buf_q[BW-DW-1:0], {DW{1'b0}}};
`endif
      cnt_d = cnt_q + CW'(1);
    end else if (is_last && bus.dig_ready) begin
      state_d = IDLE;
    end
  end

  // NOTE: sequential state uses non-blocking assignments; the buffer is reset too so dig_out reads 0.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q <= IDLE;
      buf_q   <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      buf_q   <= buf_d;
      cnt_q   <= cnt_d;
    end
  end

  assign bus.dig_valid = is_shift;
  assign bus.busy      = is_shift;
  assign bus.dig_first = is_shift && (cnt_q == '0);
  assign bus.dig_last  = is_last;
`ifdef GF163_SER_LSB_FIRST_EN
  assign bus.dig_out   = buf_q[DW-1:0];
`else
  assign bus.dig_out   = buf_q[BW-1 -: DW];
`endif

endmodule
